mxv_chunked_dot_engine: RTL

//  Parametrised matrix-vector engine: streams NUM_ROWS matrix rows as NO_OF_UNITS-lane chunks and multiplies each chunk by the matching vector chunk.

---
 rtl/mxv_pkg.sv | 45 ++++
 rtl/mxv_chunked_dot_engine_lane_mult_tree.sv | 70 +++++++
 rtl/mxv_chunked_dot_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mxv_pkg.sv
// Shared types and width helpers for the chunked matrix-vector engine.
// Width formulas are functions so each module can derive them from its own parameters.
package mxv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Index ports keep at least one bit so single-entry configurations stay legal.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int chunks_of(input int cols, input int units);
    return (cols + units - 1) / units;
  endfunction

  function automatic int prod_w(input int ew);
    return 2 * ew;
  endfunction

  function automatic int sum_w(input int ew, input int units);
    return 2 * ew + clog2(units);
  endfunction

  function automatic int acc_w(input int ew, input int chunks, input int units);
    return 2 * ew + clog2(chunks * units);
  endfunction

endpackage

// File: rtl/mxv_chunked_dot_engine_lane_mult_tree.sv
// Masked per-lane signed multipliers followed by a registered adder tree.
// A sideband tag rides along with the valid so the caller can recover row/chunk context.
module mxv_lane_mult_tree
  import mxv_pkg::*;
#(
  parameter int NO_OF_UNITS   = 8,
  parameter int ELEMENT_WIDTH = 32,
  parameter int NUM_COLS      = 16,
  parameter int CIDX_W        = 1,
  parameter int TAG_W         = 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 flush,
  input  logic                                                 vld_p0,
  input  logic [CIDX_W-1:0]                                    chunk_p0,
  input  logic [TAG_W-1:0]                                     tag_p0,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]                 row_p0,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]                 vec_p0,
  output logic                                                 vld_p2,
  output logic [TAG_W-1:0]                                     tag_p2,
  output logic signed [sum_w(ELEMENT_WIDTH, NO_OF_UNITS)-1:0]  sum_p2
);

  localparam int EW     = ELEMENT_WIDTH;
  localparam int PROD_W = prod_w(ELEMENT_WIDTH);
  localparam int SUM_W  = sum_w(ELEMENT_WIDTH, NO_OF_UNITS);

  logic signed [PROD_W-1:0] prod_c  [NO_OF_UNITS];
  logic signed [PROD_W-1:0] prod_p1 [NO_OF_UNITS];
  logic                     vld_p1;
  logic [TAG_W-1:0]         tag_p1;
  logic signed [SUM_W-1:0]  sum_c;

  // p0 -> p1: lanes past the end of the vector are forced to zero.
  always_comb begin
    for (int l = 0; l < NO_OF_UNITS; l++) begin
      prod_c[l] = '0;
      if (int'(chunk_p0) * NO_OF_UNITS + l < NUM_COLS) begin
        prod_c[l] = PROD_W'($signed(row_p0[l*EW +: EW])) * PROD_W'($signed(vec_p0[l*EW +: EW]));
      end
    end
  end

  // p1 -> p2: adder tree over sign-extended lane products.
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < NO_OF_UNITS; l++) begin
      sum_c = sum_c + SUM_W'(prod_p1[l]);
    end
  end

  always_ff @(posedge clk) begin
    prod_p1 <= prod_c;
    tag_p1  <= tag_p0;
    sum_p2  <= sum_c;
    tag_p2  <= tag_p1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

endmodule

// File: rtl/mxv_chunked_dot_engine.sv
// Streams matrix rows as lane chunks, accumulates per-row dot products against the
// vector and writes one scaled, saturated result per row with a start/done handshake.
module mxv_chunked_dot_engine
  import mxv_pkg::*;
#(
  parameter  int NO_OF_UNITS   = 8,
  parameter  int ELEMENT_WIDTH = 32,
  parameter  int NUM_ROWS      = 16,
  parameter  int NUM_COLS      = 16,
  parameter  int FRAC_BITS     = 0,
  localparam int CHUNKS        = chunks_of(NUM_COLS, NO_OF_UNITS),
  localparam int CIDX_W        = idx_w(CHUNKS),
  localparam int RIDX_W        = idx_w(NUM_ROWS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow,
  input  logic                                  row_valid,
  output logic                                  row_ready,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  row_data,
  output logic [CIDX_W-1:0]                     vec_rd_addr,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  vec_rd_data,
  output logic                                  ap_we,
  output logic [RIDX_W-1:0]                     ap_addr,
  output logic signed [ELEMENT_WIDTH-1:0]       ap_wdata
);

  localparam int EW    = ELEMENT_WIDTH;
  localparam int SUM_W = sum_w(ELEMENT_WIDTH, NO_OF_UNITS);
  localparam int ACC_W = acc_w(ELEMENT_WIDTH, CHUNKS, NO_OF_UNITS);
  localparam int TAG_W = RIDX_W + 2;

  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] v);
    return v >>> FRAC_BITS;
  endfunction

  function automatic logic clamp_hit(input logic signed [ACC_W-1:0] v);
    return (v > RES_MAX) || (v < RES_MIN);
  endfunction

  function automatic logic signed [EW-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    c = v;
    if (v > RES_MAX) c = RES_MAX;
    else if (v < RES_MIN) c = RES_MIN;
    return c[EW-1:0];
  endfunction

  state_t                  state, state_nxt;
  logic [CIDX_W-1:0]       chunk_idx;
  logic [RIDX_W-1:0]       row_idx;
  logic                    accept, last_chunk, final_beat, flush, start_go;
  logic [TAG_W-1:0]        tag_p0, tag_p2;
  logic                    vld_p2;
  logic signed [SUM_W-1:0] sum_p2;
  logic [RIDX_W-1:0]       row_p2;
  logic                    first_p2, last_p2;
  logic signed [ACC_W-1:0] acc, acc_nxt, sum_ext, scaled;

  assign row_ready   = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign accept      = row_valid & row_ready;
  assign last_chunk  = (chunk_idx == CIDX_W'(CHUNKS - 1));
  assign final_beat  = accept && last_chunk && (row_idx == RIDX_W'(NUM_ROWS - 1));
  assign flush       = abort && busy;
  assign start_go    = (state == IDLE) && start && !abort;
  assign vec_rd_addr = chunk_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (final_beat) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (ap_we && ap_addr == RIDX_W'(NUM_ROWS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_go || flush) begin
      chunk_idx <= '0;
      row_idx   <= '0;
    end else if (accept) begin
      if (last_chunk) begin
        chunk_idx <= '0;
        row_idx   <= row_idx + RIDX_W'(1);
      end else begin
        chunk_idx <= chunk_idx + CIDX_W'(1);
      end
    end
  end

  // p0: accepted beat plus the context needed when its sum emerges two cycles later.
  assign tag_p0 = {row_idx, (chunk_idx == '0), last_chunk};

  mxv_lane_mult_tree #(
    .NO_OF_UNITS   (NO_OF_UNITS),
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .NUM_COLS      (NUM_COLS),
    .CIDX_W        (CIDX_W),
    .TAG_W         (TAG_W)
  ) u_tree (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .vld_p0   (accept),
    .chunk_p0 (chunk_idx),
    .tag_p0   (tag_p0),
    .row_p0   (row_data),
    .vec_p0   (vec_rd_data),
    .vld_p2   (vld_p2),
    .tag_p2   (tag_p2),
    .sum_p2   (sum_p2)
  );

  // p2 -> p3: accumulate chunk sums; the last chunk of a row also produces the write.
  assign {row_p2, first_p2, last_p2} = tag_p2;
  assign sum_ext = ACC_W'(sum_p2);
  assign acc_nxt = first_p2 ? sum_ext : acc + sum_ext;
  assign scaled  = scale(acc_nxt);

  always_ff @(posedge clk) begin
    if (vld_p2) acc <= acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ap_we    <= 1'b0;
      ap_addr  <= '0;
      ap_wdata <= '0;
      overflow <= 1'b0;
    end else begin
      ap_we <= 1'b0;
      if (start_go) overflow <= 1'b0;
      if (vld_p2 && last_p2 && !flush) begin
        ap_we    <= 1'b1;
        ap_addr  <= row_p2;
        ap_wdata <= saturate(scaled);
        if (clamp_hit(scaled)) overflow <= 1'b1;
      end
    end
  end

endmodule
